cpu_controller: RTL

Instruction register, decoder and sequencing FSM that drives every control input of `datapath`. Latches a 16-bit instruction, decodes it on `s`, then steps the datapath through register read, ALU and write-back cycles. Asserts `w` when idle. Together with `datapath` and `regfile` it forms the lab CPU.

---
 rtl/cpu_controller_if.sv | 34 +++
 rtl/cpu_controller.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_controller_if.sv
// Control bundle between cpu_controller and the rest of the lab CPU.
// The master drives start/load/instruction; the slave (the controller) drives the datapath controls.
interface cpu_controller_if;
    logic        s;
    logic        load;
    logic [15:0] in;
    logic        w;
    logic        err;
    logic [15:0] datapath_in;
    logic        vsel;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic        write;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic [1:0]  shift;
    logic [1:0]  ALUop;

    modport master (
        output s, load, in,
        input  w, err, datapath_in, vsel, loada, loadb, loadc, loads,
               asel, bsel, write, readnum, writenum, shift, ALUop
    );

    modport slave (
        input  s, load, in,
        output w, err, datapath_in, vsel, loada, loadb, loadc, loads,
               asel, bsel, write, readnum, writenum, shift, ALUop
    );
endinterface

// File: rtl/cpu_controller.sv
// Instruction register, decoder and sequencing FSM driving the lab CPU datapath.
// Define DECODE_ERR_EN to flag illegal instructions on err; otherwise err is tied low.
module cpu_controller (
    input  logic             clk,
    input  logic             reset,
    cpu_controller_if.slave  bus
);

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_GET_A,
        S_GET_B,
        S_ALU,
        S_WR_REG,
        S_WR_IMM
    } state_t;

    typedef enum logic [2:0] {
        I_MOV_IMM,
        I_MOV_REG,
        I_ADD,
        I_CMP,
        I_AND,
        I_MVN,
        I_ILL
    } instr_t;

    function automatic instr_t decode_ir(input logic [15:0] ir);
        instr_t k;
        k = I_ILL;
        case ({ir[15:13], ir[12:11]})
            5'b110_10: k = I_MOV_IMM;
            5'b110_00: k = I_MOV_REG;
            5'b101_00: k = I_ADD;
            5'b101_01: k = I_CMP;
            5'b101_10: k = I_AND;
            5'b101_11: k = I_MVN;
            default:   k = I_ILL;
        endcase
        return k;
    endfunction

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    instr_t      kind_q, kind_d;

    logic        w_q, w_d;
    logic [15:0] dpin_q, dpin_d;
    logic        vsel_q, vsel_d;
    logic        loada_q, loada_d;
    logic        loadb_q, loadb_d;
    logic        loadc_q, loadc_d;
    logic        loads_q, loads_d;
    logic        asel_q, asel_d;
    logic        write_q, write_d;
    logic [2:0]  readnum_q, readnum_d;
    logic [2:0]  writenum_q, writenum_d;
    logic [1:0]  shift_q, shift_d;
    logic [1:0]  aluop_q, aluop_d;

    assign kind_q = decode_ir(ir_q);
    assign kind_d = decode_ir(ir_d);

    // IR only loads in WAIT, so a load pulse mid-instruction cannot disturb decode.
    assign ir_d = (state_q == S_WAIT && bus.load) ? bus.in : ir_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_WAIT:   if (bus.s) state_d = S_DECODE;
            S_DECODE: begin
                unique case (kind_q)
                    I_MOV_IMM:          state_d = S_WR_IMM;
                    I_MOV_REG, I_MVN:   state_d = S_GET_B;
                    I_ADD, I_CMP, I_AND: state_d = S_GET_A;
                    default:            state_d = S_WAIT;
                endcase
            end
            S_GET_A:  state_d = S_GET_B;
            S_GET_B:  state_d = S_ALU;
            S_ALU:    state_d = (kind_q == I_CMP) ? S_WAIT : S_WR_REG;
            S_WR_REG: state_d = S_WAIT;
            S_WR_IMM: state_d = S_WAIT;
            default:  state_d = S_WAIT;
        endcase
    end

    // Outputs are registered: decode them from the upcoming state and IR so they
    // line up with the state register instead of lagging it by a cycle.
    always_comb begin
        w_d        = (state_d == S_WAIT);
        dpin_d     = {{8{ir_d[7]}}, ir_d[7:0]};
        vsel_d     = 1'b0;
        loada_d    = 1'b0;
        loadb_d    = 1'b0;
        loadc_d    = 1'b0;
        loads_d    = 1'b0;
        asel_d     = 1'b0;
        write_d    = 1'b0;
        readnum_d  = '0;
        writenum_d = '0;
        shift_d    = '0;
        aluop_d    = '0;
        unique case (state_d)
            S_GET_A: begin
                readnum_d = ir_d[10:8];
                loada_d   = 1'b1;
            end
            S_GET_B: begin
                readnum_d = ir_d[2:0];
                loadb_d   = 1'b1;
            end
            S_ALU: begin
                shift_d = ir_d[4:3];
                unique case (kind_d)
                    I_MOV_REG: begin asel_d = 1'b1; aluop_d = 2'b00; loadc_d = 1'b1; end
                    I_ADD:     begin aluop_d = 2'b00; loadc_d = 1'b1; end
                    I_AND:     begin aluop_d = 2'b10; loadc_d = 1'b1; end
                    I_MVN:     begin asel_d = 1'b1; aluop_d = 2'b11; loadc_d = 1'b1; end
                    I_CMP:     begin aluop_d = 2'b01; loads_d = 1'b1; end
                    default:   ;
                endcase
            end
            S_WR_REG: begin
                write_d    = 1'b1;
                writenum_d = ir_d[7:5];
            end
            S_WR_IMM: begin
                vsel_d     = 1'b1;
                write_d    = 1'b1;
                writenum_d = ir_d[10:8];
            end
            default: ;
        endcase
    end

`ifdef DECODE_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (state_q == S_WAIT && bus.s)
            err_d = 1'b0;
        else if (state_q == S_DECODE && kind_q == I_ILL)
            err_d = 1'b1;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_WAIT;
            ir_q       <= '0;
            w_q        <= 1'b1;
            dpin_q     <= '0;
            vsel_q     <= 1'b0;
            loada_q    <= 1'b0;
            loadb_q    <= 1'b0;
            loadc_q    <= 1'b0;
            loads_q    <= 1'b0;
            asel_q     <= 1'b0;
            write_q    <= 1'b0;
            readnum_q  <= '0;
            writenum_q <= '0;
            shift_q    <= '0;
            aluop_q    <= '0;
`ifdef DECODE_ERR_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            w_q        <= w_d;
            dpin_q     <= dpin_d;
            vsel_q     <= vsel_d;
            loada_q    <= loada_d;
            loadb_q    <= loadb_d;
            loadc_q    <= loadc_d;
            loads_q    <= loads_d;
            asel_q     <= asel_d;
            write_q    <= write_d;
            readnum_q  <= readnum_d;
            writenum_q <= writenum_d;
            shift_q    <= shift_d;
            aluop_q    <= aluop_d;
`ifdef DECODE_ERR_EN
            err_q      <= err_d;
`endif
        end
    end

    assign bus.w           = w_q;
    assign bus.datapath_in = dpin_q;
    assign bus.vsel        = vsel_q;
    assign bus.loada       = loada_q;
    assign bus.loadb       = loadb_q;
    assign bus.loadc       = loadc_q;
    assign bus.loads       = loads_q;
    assign bus.asel        = asel_q;
    assign bus.bsel        = 1'b0;
    assign bus.write       = write_q;
    assign bus.readnum     = readnum_q;
    assign bus.writenum    = writenum_q;
    assign bus.shift       = shift_q;
    assign bus.ALUop       = aluop_q;
`ifdef DECODE_ERR_EN
    assign bus.err         = err_q;
`else
    assign bus.err         = 1'b0;
`endif

endmodule
